uart_tx_cfg: RTL and testbench

Parametrised UART transmitter with a built-in transmit FIFO. The data width, parity mode, stop-bit count, bit period and FIFO depth are all configurable. It is the next generation of the fixed 8N1 single-byte `uart_tx`. Producers can queue several words without waiting for `o_Tx_Done`. Frames then go out back-to-back on `o_Tx_Serial`.

---
 rtl/uart_tx_cfg.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a small transmit FIFO in front of the serializer.
// Serializer outputs are registered from the current state, so the line lags the FSM by one cycle.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Tx_DV,
  input  logic [DATA_BITS-1:0]          i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CLK_W = $clog2(CLKS_PER_BIT * 2);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [CLK_W-1:0] BIT_LAST  = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [CLK_W-1:0] STOP_LAST = CLK_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data);
    return (PARITY == 1) ? ~(^data) : ^data;
  endfunction

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  state_t               state_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 parity_r;
  logic [CLK_W-1:0]     clk_cnt_r;
  logic [BIT_W-1:0]     bit_idx_r;
  logic                 serial_r;
  logic                 active_r;
  logic                 done_r;

  logic                 ready_s;
  logic                 wr_en_s;
  logic                 pop_s;
  logic [DATA_BITS-1:0] head_s;

  // Ready comes from the registered count only, so a same-cycle pop never admits a write into a full FIFO.
  assign ready_s = (count_r != FULL_CNT);
  assign wr_en_s = i_Tx_DV & ready_s;
  assign pop_s   = (state_r == S_IDLE) && (count_r != {CNT_W{1'b0}});
  assign head_s  = mem_r[rd_ptr_r];

  assign o_Tx_Ready   = ready_s;
  assign o_Fifo_Count = count_r;
  assign o_Tx_Active  = active_r;
  assign o_Tx_Serial  = serial_r;
  assign o_Tx_Done    = done_r;

  // FIFO storage write port
  always_ff @(posedge i_Clock) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= i_Tx_Byte;
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Serializer FSM with outputs registered from the current state
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_r   <= S_IDLE;
      shift_r   <= {DATA_BITS{1'b0}};
      parity_r  <= 1'b0;
      clk_cnt_r <= {CLK_W{1'b0}};
      bit_idx_r <= {BIT_W{1'b0}};
      serial_r  <= 1'b1;
      active_r  <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          serial_r  <= 1'b1;
          active_r  <= 1'b0;
          done_r    <= 1'b0;
          clk_cnt_r <= {CLK_W{1'b0}};
          bit_idx_r <= {BIT_W{1'b0}};
          if (pop_s) begin
            shift_r  <= head_s;
            parity_r <= parity_bit(head_s);
            state_r  <= S_START;
          end
        end
        S_START: begin
          serial_r <= 1'b0;
          active_r <= 1'b1;
          done_r   <= 1'b0;
          if (clk_cnt_r == BIT_LAST) begin
            clk_cnt_r <= {CLK_W{1'b0}};
            state_r   <= S_DATA;
          end else begin
            clk_cnt_r <= clk_cnt_r + CLK_W'(1);
          end
        end
        S_DATA: begin
          serial_r <= shift_r[0];
          active_r <= 1'b1;
          done_r   <= 1'b0;
          if (clk_cnt_r == BIT_LAST) begin
            clk_cnt_r <= {CLK_W{1'b0}};
            shift_r   <= shift_r >> 1;
            if (bit_idx_r == DATA_LAST) begin
              bit_idx_r <= {BIT_W{1'b0}};
              state_r   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + BIT_W'(1);
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CLK_W'(1);
          end
        end
        S_PARITY: begin
          serial_r <= parity_r;
          active_r <= 1'b1;
          done_r   <= 1'b0;
          if (clk_cnt_r == BIT_LAST) begin
            clk_cnt_r <= {CLK_W{1'b0}};
            state_r   <= S_STOP;
          end else begin
            clk_cnt_r <= clk_cnt_r + CLK_W'(1);
          end
        end
        S_STOP: begin
          serial_r <= 1'b1;
          active_r <= 1'b1;
          done_r   <= 1'b0;
          if (clk_cnt_r == STOP_LAST) begin
            clk_cnt_r <= {CLK_W{1'b0}};
            state_r   <= S_DONE;
          end else begin
            clk_cnt_r <= clk_cnt_r + CLK_W'(1);
          end
        end
        S_DONE: begin
          serial_r <= 1'b1;
          active_r <= 1'b0;
          done_r   <= 1'b1;
          state_r  <= S_IDLE;
        end
        default: begin
          serial_r  <= 1'b1;
          active_r  <= 1'b0;
          done_r    <= 1'b0;
          clk_cnt_r <= {CLK_W{1'b0}};
          bit_idx_r <= {BIT_W{1'b0}};
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: four configurations share one clock and a selectable frame monitor.
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rst_q;
  logic [7:0] wdata;
  logic       dv_m, dv_e, dv_o, dv_n;

  logic       rdy_m, act_m, ser_m, done_m;
  logic       rdy_e, act_e, ser_e, done_e;
  logic       rdy_o, act_o, ser_o, done_o;
  logic       rdy_n, act_n, ser_n, done_n;
  logic [2:0] cnt_m, cnt_e, cnt_o, cnt_n;

  uart_tx_cfg #(.CLKS_PER_BIT(4)) u_main (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv_m), .i_Tx_Byte(wdata),
    .o_Tx_Ready(rdy_m), .o_Fifo_Count(cnt_m), .o_Tx_Active(act_m),
    .o_Tx_Serial(ser_m), .o_Tx_Done(done_m));

  uart_tx_cfg #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) u_even (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv_e), .i_Tx_Byte(wdata),
    .o_Tx_Ready(rdy_e), .o_Fifo_Count(cnt_e), .o_Tx_Active(act_e),
    .o_Tx_Serial(ser_e), .o_Tx_Done(done_e));

  uart_tx_cfg #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) u_odd (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv_o), .i_Tx_Byte(wdata),
    .o_Tx_Ready(rdy_o), .o_Fifo_Count(cnt_o), .o_Tx_Active(act_o),
    .o_Tx_Serial(ser_o), .o_Tx_Done(done_o));

  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(5)) u_narrow (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv_n), .i_Tx_Byte(wdata[4:0]),
    .o_Tx_Ready(rdy_n), .o_Fifo_Count(cnt_n), .o_Tx_Active(act_n),
    .o_Tx_Serial(ser_n), .o_Tx_Done(done_n));

  int         sel;
  logic       s_rdy, s_act, s_ser, s_done;
  logic [2:0] s_cnt;

  always_comb begin
    case (sel)
      1:       begin s_rdy = rdy_e; s_act = act_e; s_ser = ser_e; s_done = done_e; s_cnt = cnt_e; end
      2:       begin s_rdy = rdy_o; s_act = act_o; s_ser = ser_o; s_done = done_o; s_cnt = cnt_o; end
      3:       begin s_rdy = rdy_n; s_act = act_n; s_ser = ser_n; s_done = done_n; s_cnt = cnt_n; end
      default: begin s_rdy = rdy_m; s_act = act_m; s_ser = ser_m; s_done = done_m; s_cnt = cnt_m; end
    endcase
  end

  typedef struct {
    logic [63:0] vec;
    int          len;
    int          gap;
    logic        done_ok;
    logic [2:0]  cnt;
  } frame_t;

  frame_t     obs_q[$];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         done_total = 0;

  always @(posedge clk) rst_q <= rst;

  // Frame recorder: captures the selected line per cycle while active; gap counts idle samples before a frame.
  initial begin
    frame_t      fr;
    logic [63:0] vec;
    int          len, gap_cnt, cur_gap;
    bit          in_frame;
    vec = '0; len = 0; gap_cnt = 0; cur_gap = 0; in_frame = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_q === 1'b1) begin
        in_frame = 1'b0; gap_cnt = 0; len = 0;
      end else if (s_act === 1'b1) begin
        if (!in_frame) begin
          in_frame = 1'b1; cur_gap = gap_cnt; len = 0; vec = '0;
        end
        if (len < 64) vec[len] = s_ser;
        len++;
      end else begin
        if (in_frame) begin
          fr.vec = vec; fr.len = len; fr.gap = cur_gap;
          fr.done_ok = (s_done === 1'b1) && (s_ser === 1'b1);
          fr.cnt = s_cnt;
          obs_q.push_back(fr);
          in_frame = 1'b0; gap_cnt = 0;
        end
        gap_cnt++;
      end
      if (s_done === 1'b1) done_total++;
    end
  end

  // Reference line waveform for one frame at 4 clocks per bit.
  function automatic logic [63:0] build_vec(input logic [7:0] w, input int db, input int par, input int sb);
    logic [63:0] v;
    int          p;
    logic        pb;
    v = '0; p = 0; pb = 1'b0;
    for (int c = 0; c < 4; c++) begin v[p] = 1'b0; p++; end
    for (int b = 0; b < db; b++) begin
      pb = pb ^ w[b];
      for (int c = 0; c < 4; c++) begin v[p] = w[b]; p++; end
    end
    if (par != 0) begin
      if (par == 1) pb = ~pb;
      for (int c = 0; c < 4; c++) begin v[p] = pb; p++; end
    end
    for (int c = 0; c < 4 * sb; c++) begin v[p] = 1'b1; p++; end
    return v;
  endfunction

  task automatic wr(input int which, input logic [7:0] w, input bit acc);
    wdata = w;
    case (which)
      1:       dv_e = 1'b1;
      2:       dv_o = 1'b1;
      3:       dv_n = 1'b1;
      default: dv_m = 1'b1;
    endcase
    if (acc) exp_q.push_back(w);
    @(negedge clk);
    dv_m = 1'b0; dv_e = 1'b0; dv_o = 1'b0; dv_n = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int t;
    t = 0;
    while (obs_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ser_m !== 1'b1 || act_m !== 1'b0 || done_m !== 1'b0 || cnt_m !== 3'd0 || rdy_m !== 1'b1) begin
      failures++;
      $display("FAIL reset_state ser=%b act=%b done=%b cnt=%0d rdy=%b required 1 0 0 0 1",
               ser_m, act_m, done_m, cnt_m, rdy_m);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_default_frame();
    frame_t     fr;
    logic [7:0] w;
    bit         ok;
    int         d0;
    sel = 0; d0 = done_total;
    wr(0, 8'hA3, 1'b1);
    @(negedge clk);
    checks++;
    if (s_ser !== 1'b1 || s_act !== 1'b0) begin
      failures++; $display("FAIL latency_n1 ser=%b act=%b required ser=1 act=0", s_ser, s_act);
    end
    @(negedge clk);
    checks++;
    if (s_ser !== 1'b0 || s_act !== 1'b1) begin
      failures++; $display("FAIL latency_n2 ser=%b act=%b required ser=0 act=1", s_ser, s_act);
    end
    wait_frames(1, 200, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL default_timeout frames=%0d required 1", obs_q.size());
    end else begin
      fr = obs_q.pop_front(); w = exp_q.pop_front();
      checks += 3;
      if (fr.vec !== build_vec(w, 8, 0, 1)) begin
        failures++; $display("FAIL default_line got=%h required=%h", fr.vec, build_vec(w, 8, 0, 1));
      end
      if (fr.len != 40) begin
        failures++; $display("FAIL default_active_len got=%0d required=40", fr.len);
      end
      if (fr.done_ok !== 1'b1) begin
        failures++; $display("FAIL default_done got=%b required=1", fr.done_ok);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_total - d0 != 1) begin
      failures++; $display("FAIL default_done_count got=%0d required=1", done_total - d0);
    end
  endtask

  task automatic test_parity();
    frame_t     fr;
    logic [7:0] w;
    bit         ok;
    int         par;
    logic       exp_pb;
    for (int k = 0; k < 2; k++) begin
      sel = 1 + k;
      par = (k == 0) ? 2 : 1;
      exp_pb = (k == 0) ? 1'b0 : 1'b1;
      wr(sel, 8'hA3, 1'b1);
      wait_frames(1, 200, ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL parity%0d_timeout frames=%0d required 1", par, obs_q.size());
      end else begin
        fr = obs_q.pop_front(); w = exp_q.pop_front();
        checks += 4;
        if (fr.vec !== build_vec(w, 8, par, 2)) begin
          failures++; $display("FAIL parity%0d_line got=%h required=%h", par, fr.vec, build_vec(w, 8, par, 2));
        end
        if (fr.vec[37] !== exp_pb) begin
          failures++; $display("FAIL parity%0d_bit got=%b required=%b", par, fr.vec[37], exp_pb);
        end
        if (fr.len != 48) begin
          failures++; $display("FAIL parity%0d_len got=%0d required=48", par, fr.len);
        end
        if (fr.done_ok !== 1'b1) begin
          failures++; $display("FAIL parity%0d_done got=%b required=1", par, fr.done_ok);
        end
      end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_narrow();
    frame_t     fr;
    logic [7:0] w;
    logic [4:0] bits;
    bit         ok;
    sel = 3;
    wr(3, 8'h16, 1'b1);
    wait_frames(1, 200, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL narrow_timeout frames=%0d required 1", obs_q.size());
    end else begin
      fr = obs_q.pop_front(); w = exp_q.pop_front();
      for (int b = 0; b < 5; b++) bits[b] = fr.vec[4 * (1 + b) + 2];
      checks += 3;
      if (bits !== 5'b10110) begin
        failures++; $display("FAIL narrow_bits got=%b required=10110", bits);
      end
      if (fr.vec !== build_vec(w, 5, 0, 1)) begin
        failures++; $display("FAIL narrow_line got=%h required=%h", fr.vec, build_vec(w, 5, 0, 1));
      end
      if (fr.len != 28) begin
        failures++; $display("FAIL narrow_len got=%0d required=28", fr.len);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fifo_full();
    frame_t     fr;
    logic [7:0] w;
    bit         ok;
    logic       exp_rdy;
    sel = 0;
    for (int i = 1; i <= 6; i++) begin
      exp_rdy = (i <= 5);
      checks++;
      if (s_rdy !== exp_rdy) begin
        failures++; $display("FAIL fifo_ready_w%0d got=%b required=%b", i, s_rdy, exp_rdy);
      end
      wr(0, 8'(i), i <= 5);
    end
    checks++;
    if (s_cnt !== 3'd4) begin
      failures++; $display("FAIL fifo_count_full got=%0d required=4", s_cnt);
    end
    wait_frames(5, 600, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL fifo_timeout frames=%0d required 5", obs_q.size());
    end else begin
      for (int k = 1; k <= 5; k++) begin
        fr = obs_q.pop_front(); w = exp_q.pop_front();
        checks += 4;
        if (fr.vec !== build_vec(w, 8, 0, 1)) begin
          failures++; $display("FAIL fifo_line_f%0d got=%h required=%h", k, fr.vec, build_vec(w, 8, 0, 1));
        end
        if (fr.len != 40) begin
          failures++; $display("FAIL fifo_len_f%0d got=%0d required=40", k, fr.len);
        end
        if (fr.done_ok !== 1'b1) begin
          failures++; $display("FAIL fifo_done_f%0d got=%b required=1", k, fr.done_ok);
        end
        if (fr.cnt !== 3'(5 - k)) begin
          failures++; $display("FAIL fifo_count_f%0d got=%0d required=%0d", k, fr.cnt, 5 - k);
        end
        if (k > 1) begin
          checks++;
          if (fr.gap != 2) begin
            failures++; $display("FAIL fifo_gap_f%0d got=%0d required=2", k, fr.gap);
          end
        end
      end
    end
    repeat (60) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || s_cnt !== 3'd0) begin
      failures++; $display("FAIL fifo_drop extra_frames=%0d cnt=%0d required 0 0", obs_q.size(), s_cnt);
    end
  endtask

  task automatic test_simultaneous();
    frame_t     fr;
    logic [7:0] w;
    bit         ok;
    int         t;
    sel = 0;
    wr(0, 8'h11, 1'b1); wr(0, 8'h22, 1'b1); wr(0, 8'h33, 1'b1); wr(0, 8'h44, 1'b1);
    t = 0;
    while (s_done !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (s_done !== 1'b1 || s_cnt !== 3'd3) begin
      failures++; $display("FAIL simul_pre done=%b cnt=%0d required 1 3", s_done, s_cnt);
    end
    wr(0, 8'h55, 1'b1);
    checks++;
    if (s_cnt !== 3'd3) begin
      failures++; $display("FAIL simul_count got=%0d required=3", s_cnt);
    end
    wait_frames(5, 600, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL simul_timeout frames=%0d required 5", obs_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        fr = obs_q.pop_front(); w = exp_q.pop_front();
        checks += 2;
        if (fr.vec !== build_vec(w, 8, 0, 1)) begin
          failures++; $display("FAIL simul_line_f%0d got=%h required=%h", k, fr.vec, build_vec(w, 8, 0, 1));
        end
        if (k > 0 && fr.gap != 2) begin
          failures++; $display("FAIL simul_gap_f%0d got=%0d required=2", k, fr.gap);
        end else if (k == 0 && fr.len != 40) begin
          failures++; $display("FAIL simul_len_f0 got=%0d required=40", fr.len);
        end
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    frame_t     fr;
    logic [7:0] w;
    bit         ok;
    int         d0;
    sel = 0;
    wr(0, 8'h61, 1'b1); wr(0, 8'h62, 1'b1); wr(0, 8'h63, 1'b1);
    repeat (8) @(negedge clk);
    checks++;
    if (s_act !== 1'b1 || s_cnt !== 3'd2) begin
      failures++; $display("FAIL midrst_pre act=%b cnt=%0d required 1 2", s_act, s_cnt);
    end
    d0 = done_total;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if (s_ser !== 1'b1 || s_act !== 1'b0 || s_done !== 1'b0 || s_cnt !== 3'd0 || s_rdy !== 1'b1) begin
      failures++; $display("FAIL midrst_after ser=%b act=%b done=%b cnt=%0d rdy=%b required 1 0 0 0 1",
                           s_ser, s_act, s_done, s_cnt, s_rdy);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (done_total != d0 || obs_q.size() != 0 || s_ser !== 1'b1) begin
      failures++; $display("FAIL midrst_quiet done_pulses=%0d frames=%0d ser=%b required 0 0 1",
                           done_total - d0, obs_q.size(), s_ser);
    end
    wr(0, 8'h5C, 1'b1);
    @(negedge clk);
    checks++;
    if (s_ser !== 1'b1 || s_act !== 1'b0) begin
      failures++; $display("FAIL midrst_lat_n1 ser=%b act=%b required 1 0", s_ser, s_act);
    end
    @(negedge clk);
    checks++;
    if (s_ser !== 1'b0 || s_act !== 1'b1) begin
      failures++; $display("FAIL midrst_lat_n2 ser=%b act=%b required 0 1", s_ser, s_act);
    end
    wait_frames(1, 200, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL midrst_timeout frames=%0d required 1", obs_q.size());
    end else begin
      fr = obs_q.pop_front(); w = exp_q.pop_front();
      checks += 2;
      if (fr.vec !== build_vec(w, 8, 0, 1)) begin
        failures++; $display("FAIL midrst_line got=%h required=%h", fr.vec, build_vec(w, 8, 0, 1));
      end
      if (fr.len != 40 || fr.done_ok !== 1'b1) begin
        failures++; $display("FAIL midrst_frame len=%0d done=%b required 40 1", fr.len, fr.done_ok);
      end
    end
  endtask

  initial begin
    rst = 1'b1; wdata = 8'h00; sel = 0;
    dv_m = 1'b0; dv_e = 1'b0; dv_o = 1'b0; dv_n = 1'b0;
    test_reset();
    test_default_frame();
    test_parity();
    test_narrow();
    test_fifo_full();
    test_simultaneous();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
